// File: rtl/disp_scan_4dig.sv
// ---------------------------------------------------------------------------
// disp_scan_4dig
//
// Four-digit time-multiplexed display scanner feeding a hex-to-seven-segment
// decoder. A 16-bit hex value with per-digit decimal point and blank controls
// is double-buffered: load captures into a shadow copy, and the shadow is
// committed to the active copy only at a frame boundary (the tick that wraps
// the scan from digit 3 back to digit 0), so a frame never shows a mix of
// old and new data.
//
// Parameters
//   SCAN_DIV  clock cycles each digit is held (>= 2)
//   DIV_W     prescaler width, 2**DIV_W >= SCAN_DIV
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   data_in      four hex digits, digit 0 in bits [3:0] (rightmost)
//   point_in     decimal point per digit, 1 = lit
//   le_in        blank per digit, 1 = blanked
//   lz_blank     1 = blank leading zeros (digit 0 never zero-blanked)
//   load         single-cycle strobe, captures data/point/le into the shadow
//   load_ack     one-cycle pulse when the shadow is committed
//   hex          nibble to the decoder
//   point        decimal point to the decoder, 1 = lit
//   le           blank to the decoder LE input, 1 = blanked
//   an           anode select, active-low, one-hot-zero
//   frame_start  one-cycle pulse when the scan wraps to digit 0
// ---------------------------------------------------------------------------
module disp_scan_4dig #(
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  point_in,
  input  logic [3:0]  le_in,
  input  logic        lz_blank,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  hex,
  output logic        point,
  output logic        le,
  output logic [3:0]  an,
  output logic        frame_start
);

  // Leading-zero blank for digit k: digits k..3 of the value are all zero.
  // Digit 0 always shows, so an all-zero value still displays "0".
  function automatic logic f_lzb(input logic [15:0] d,
                                 input logic [1:0]  k,
                                 input logic        en);
    logic z;
    case (k)
      2'd1:    z = (d[15:4]  == 12'h000);
      2'd2:    z = (d[15:8]  == 8'h00);
      2'd3:    z = (d[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return en & z;
  endfunction

  // Scan timing state
  logic [DIV_W-1:0] r_cnt;
  logic [1:0]       r_idx;

  // Shadow (pending) copy
  logic [15:0]      r_sh_data;
  logic [3:0]       r_sh_point;
  logic [3:0]       r_sh_le;
  logic             r_pend;

  // Active copy, the one being displayed
  logic [15:0]      r_act_data;
  logic [3:0]       r_act_point;
  logic [3:0]       r_act_le;

  // Registered outputs
  logic [3:0]       r_hex;
  logic             r_point;
  logic             r_le;
  logic [3:0]       r_an;
  logic             r_load_ack;
  logic             r_frame_start;

  // Combinational next-state values
  logic             w_tick;
  logic             w_wrap;
  logic             w_commit;
  logic [1:0]       w_idx_nxt;
  logic [15:0]      w_act_data_nxt;
  logic [3:0]       w_act_point_nxt;
  logic [3:0]       w_act_le_nxt;
  logic [3:0]       w_hex_nxt;
  logic             w_point_nxt;
  logic             w_le_nxt;
  logic [3:0]       w_an_nxt;

  always_comb begin
    w_tick    = (r_cnt == DIV_W'(SCAN_DIV - 1));
    w_wrap    = w_tick && (r_idx == 2'd3);
    w_commit  = w_wrap && r_pend;
    w_idx_nxt = w_tick ? (r_idx + 2'd1) : r_idx;

    // The outputs loaded on a commit edge must already show the new frame,
    // so they are computed from the post-commit view of the active copy.
    w_act_data_nxt  = w_commit ? r_sh_data  : r_act_data;
    w_act_point_nxt = w_commit ? r_sh_point : r_act_point;
    w_act_le_nxt    = w_commit ? r_sh_le    : r_act_le;

    w_hex_nxt   = w_act_data_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_point_nxt = w_act_point_nxt[w_idx_nxt];
    w_le_nxt    = w_act_le_nxt[w_idx_nxt]
                | f_lzb(w_act_data_nxt, w_idx_nxt, lz_blank);
    w_an_nxt    = ~(4'b0001 << w_idx_nxt);
  end

  // ---- prescaler and digit index ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      r_cnt <= w_tick ? '0 : (r_cnt + DIV_W'(1));
      r_idx <= w_idx_nxt;
    end
  end

  // ---- shadow capture and pending flag ----
  // A load on the commit edge lands in the shadow after the old shadow has
  // been committed, and keeps pending set for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_data  <= 16'h0000;
      r_sh_point <= 4'b0000;
      r_sh_le    <= 4'b1111;
      r_pend     <= 1'b0;
    end else begin
      if (load) begin
        r_sh_data  <= data_in;
        r_sh_point <= point_in;
        r_sh_le    <= le_in;
        r_pend     <= 1'b1;
      end else if (w_commit) begin
        r_pend     <= 1'b0;
      end
    end
  end

  // ---- active copy ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_data  <= 16'h0000;
      r_act_point <= 4'b0000;
      r_act_le    <= 4'b1111;
    end else begin
      r_act_data  <= w_act_data_nxt;
      r_act_point <= w_act_point_nxt;
      r_act_le    <= w_act_le_nxt;
    end
  end

  // ---- decoder / anode outputs, all moving together on tick ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex   <= 4'h0;
      r_point <= 1'b0;
      r_le    <= 1'b1;
      r_an    <= 4'b1110;
    end else if (w_tick) begin
      r_hex   <= w_hex_nxt;
      r_point <= w_point_nxt;
      r_le    <= w_le_nxt;
      r_an    <= w_an_nxt;
    end
  end

  // ---- frame pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_ack    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_load_ack    <= w_commit;
      r_frame_start <= w_wrap;
    end
  end

  assign hex         = r_hex;
  assign point       = r_point;
  assign le          = r_le;
  assign an          = r_an;
  assign load_ack    = r_load_ack;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_disp_scan_4dig.sv
// ---------------------------------------------------------------------------
// tb_disp_scan_4dig
//
// Bench for disp_scan_4dig with SCAN_DIV=4. A reference model advances on
// every clock edge from the count of edges since reset: the displayed digit is
// (n / SCAN_DIV) mod 4 and frame boundaries fall at multiples of 4*SCAN_DIV.
// It queues the expected output tuple for each cycle; a monitor on the falling
// edge pops and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_disp_scan_4dig;

  localparam int SD = 4;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] data_in = 16'h0;
  logic [3:0]  point_in = 4'h0;
  logic [3:0]  le_in = 4'h0;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [3:0]  hex;
  logic        point;
  logic        le;
  logic [3:0]  an;
  logic        frame_start;

  disp_scan_4dig #(.SCAN_DIV(SD), .DIV_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .point_in    (point_in),
    .le_in       (le_in),
    .lz_blank    (lz_blank),
    .load        (load),
    .load_ack    (load_ack),
    .hex         (hex),
    .point       (point),
    .le          (le),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] hex;
    logic       pt;
    logic       le;
    logic [3:0] an;
    logic       ack;
    logic       fs;
  } exp_t;

  exp_t exq[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          n;
  logic [15:0] m_sh_d, m_act_d;
  logic [3:0]  m_sh_p, m_sh_l, m_act_p, m_act_l;
  bit          m_pend;
  exp_t        cur;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      m_sh_d = 16'h0; m_act_d = 16'h0;
      m_sh_p = 4'h0;  m_act_p = 4'h0;
      m_sh_l = 4'hF;  m_act_l = 4'hF;
      m_pend = 0;
      cur.hex = 4'h0; cur.pt = 1'b0; cur.le = 1'b1;
      cur.an = 4'b1110; cur.ack = 1'b0; cur.fs = 1'b0;
      exq.delete();
      exq.push_back(cur);
    end else begin
      n++;
      cur.ack = 1'b0;
      cur.fs  = 1'b0;
      if (n % FR == 0) begin
        cur.fs = 1'b1;
        if (m_pend) begin
          m_act_d = m_sh_d; m_act_p = m_sh_p; m_act_l = m_sh_l;
          m_pend  = 0;
          cur.ack = 1'b1;
        end
      end
      if (load) begin
        m_sh_d = data_in; m_sh_p = point_in; m_sh_l = le_in;
        m_pend = 1;
      end
      if (n % SD == 0) begin
        int d;
        d = (n / SD) % 4;
        cur.an  = ~(4'b0001 << d);
        cur.hex = m_act_d[4*d +: 4];
        cur.pt  = m_act_p[d];
        cur.le  = m_act_l[d] | (lz_blank && d != 0 && (m_act_d >> (4*d)) == 16'h0);
      end
      exq.push_back(cur);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exq.size() > 0) begin
      exp_t e;
      e = exq.pop_front();
      chk("outputs", {14'h0, hex, point, le, an, load_ack, frame_start},
                     {14'h0, e.hex, e.pt, e.le, e.an, e.ack, e.fs});
      if (load_ack === 1'b1) ack_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] l);
    data_in = d; point_in = p; le_in = l; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int guard;
    guard = 0;
    while ((n % FR) != ph && guard < 2 * FR) begin
      cyc(1);
      guard++;
    end
    if (guard >= 2 * FR) chk("phase_wait_timeout", 1, 0);
  endtask

  // Asynchronous reset in the middle of a cycle with an immediate check.
  task automatic mid_reset(input string name);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({name, "_an"}, {28'h0, an}, 32'hE);
    chk({name, "_hex"}, {28'h0, hex}, 32'h0);
    chk({name, "_le"}, {31'h0, le}, 32'h1);
    chk({name, "_ack"}, {31'h0, load_ack}, 32'h0);
    cyc(2);
    rst_n = 1'b1;
  endtask

  int a0;

  initial begin
    #2 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;

    // idle after reset: all digits blanked
    cyc(40);

    // basic scan
    lz_blank = 1'b0;
    do_load(16'h1234, 4'b0100, 4'b0000);
    cyc(50);

    // reset mid-scan
    cyc(5);
    mid_reset("reset_midscan");
    cyc(36);

    // leading-zero blanking
    lz_blank = 1'b1;
    do_load(16'h0050, 4'b0000, 4'b0000);
    cyc(40);
    do_load(16'h0000, 4'b0000, 4'b0000);
    cyc(40);
    lz_blank = 1'b0;

    // last load wins
    wait_phase(1);
    a0 = ack_seen;
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    cyc(3);
    do_load(16'hBBBB, 4'b0000, 4'b0000);
    cyc(40);
    chk("last_load_wins_acks", ack_seen - a0, 1);

    // load on the commit edge
    wait_phase(2);
    a0 = ack_seen;
    do_load(16'h1111, 4'b0001, 4'b0000);
    wait_phase(FR - 1);
    do_load(16'h2222, 4'b0010, 4'b0000);
    cyc(40);
    chk("commit_edge_acks", ack_seen - a0, 2);

    // reset while a load is pending
    mid_reset("reset_pre");
    cyc(20);
    wait_phase(1);
    do_load(16'hFFFF, 4'b1111, 4'b0000);
    cyc(3);
    a0 = ack_seen;
    mid_reset("reset_pending");
    cyc(40);
    chk("reset_pending_acks", ack_seen - a0, 0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [15:0] mask;
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      if (i % 37 == 0) lz_blank = $urandom_range(0, 1);
      if (i == 250) begin
        mid_reset("reset_random");
      end else if ($urandom_range(0, 7) == 0) begin
        do_load(16'($urandom) & mask, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
      end else begin
        cyc(1);
      end
    end
    cyc(2 * FR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/disp_scan_4dig.md
# disp_scan_4dig

Four-digit time-multiplexed display scanner that sits directly upstream of the hex-to-seven-segment decoder. It holds a 16-bit hex value with per-digit decimal-point and blank controls. It steps through the digits at a programmable rate and presents one nibble, its point bit and its blank (LE) bit to the decoder, together with the active-low anode select. New data is double-buffered and committed only at a frame boundary, so the display never tears.

## Interface
- SCAN_DIV, 50000, clock cycles each digit is held (≥2)
- DIV_W, 16, prescaler width; must satisfy 2^DIV_W ≥ SCAN_DIV
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- data_in  in  16  hex digits; digit k = data_in[4k+3:4k], digit 0 rightmost
- point_in  in  4  decimal point per digit, 1 = lit
- le_in  in  4  blank per digit, 1 = blanked
- lz_blank  in  1  1 = enable leading-zero blanking
- load  in  1  single-cycle strobe; capture data_in/point_in/le_in into shadow
- load_ack  out  1  one-cycle pulse when shadow is committed to the active registers
- hex  out  4  nibble to decoder D3..D0
- point  out  1  point to decoder, 1 = lit
- le  out  1  blank to decoder LE, 1 = blanked
- an  out  4  anode select, active-low, one-hot-zero
- frame_start  out  1  one-cycle pulse when scan wraps to digit 0

## Operation
- Prescaler counts 0..SCAN_DIV-1 and wraps. tick = (count == SCAN_DIV-1).
- Scan index idx (2 bits) advances on tick: 0→1→2→3→0.
- Shadow registers (data, point, le) plus a pending flag:
  - load=1 captures the inputs into shadow and sets pending.
  - A repeated load while pending overwrites the shadow; the last load wins.
- Commit occurs on the edge where tick=1, idx=3 and pending=1:
  - The active registers take the shadow contents held before that edge.
  - load_ack=1 for that cycle; pending clears.
- If load coincides with the commit edge:
  - The old shadow is committed and load_ack pulses.
  - The new inputs enter the shadow and pending stays 1, so they commit at the next frame boundary with a second ack.
- Outputs are registered and update on each tick edge, using idx_next and the post-commit active data:
  - an = ~(4'b0001 << idx_next)
  - hex = active nibble[idx_next]
  - point = active point[idx_next]
  - le = active le[idx_next] OR lzb(idx_next)
- Leading-zero blanking: lzb(k) = lz_blank AND k≠0 AND nibbles k..3 all zero. Digit 0 is never zero-blanked.
- frame_start=1 on the edge where idx wraps 3→0.
- Reset values (async, immediate):
  - prescaler 0, idx 0, pending 0
  - shadow and active data 16'h0000, point 4'b0000, le 4'b1111
  - hex 4'h0, point 0, le 1, an 4'b1110, load_ack 0, frame_start 0
- Reset mid-scan or mid-pending discards shadow and pending data; no ack follows.

## Timing
- Each digit is held for exactly SCAN_DIV cycles. A frame is 4·SCAN_DIV cycles.
- Output changes occur only on tick edges; all outputs change together on the same edge.
- load → shadow captured at the next rising edge.
- load → load_ack latency is 1 to 4·SCAN_DIV cycles, measured to the next frame boundary.
- New data appears on hex, point and le in the same cycle as load_ack, on digit 0.
- load_ack and frame_start are coincident when a commit occurs.
- After reset release, the first tick occurs SCAN_DIV cycles later, moving to digit 1.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 at an arbitrary mid-scan cycle.
  - Required: same cycle, an=1110, hex=0, le=1, load_ack=0. After release with no load, le stays 1 on every digit.
- Basic scan (SCAN_DIV=4):
  - Stimulus: load 16'h1234, point_in=0100, le_in=0000.
  - Required: load_ack at the frame boundary. Then an cycles 1110/1101/1011/0111 with hex 4/3/2/1, each for 4 cycles. point=1 only while an=1011. frame_start every 16 cycles.
- Leading-zero blanking:
  - Stimulus A: lz_blank=1, load 16'h0050.
  - Required A: digits 3 and 2 have le=1; digit 1 shows hex=5, le=0; digit 0 shows hex=0, le=0.
  - Stimulus B: load 16'h0000.
  - Required B: only digit 0 is unblanked.
- Last-load-wins:
  - Stimulus: load 16'hAAAA, then 16'hBBBB, within one frame.
  - Required: exactly one load_ack. Display shows BBBB; hex never shows A.
- Load on commit edge:
  - Stimulus: pending 16'h1111; load 16'h2222 on the commit edge.
  - Required: ack, then 1111 displayed for one frame. Second ack, then 2222 displayed.
- Reset with pending:
  - Stimulus: load 16'hFFFF, then assert rst_n=0 before the frame boundary.
  - Required: no load_ack after release; all digits stay blanked.
